// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types and helpers for the 4-way decode issue controller.
package decode_issue_ctrl_pkg;

  localparam int DECODE_WAYS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Lane-valid mask with the lowest n lanes set.
  function automatic logic [DECODE_WAYS-1:0] thermo(input logic [2:0] n);
    logic [DECODE_WAYS-1:0] t;
    t = '0;
    for (int i = 0; i < DECODE_WAYS; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/decode_perf_cnt.sv
// Performance counters for the decode issue controller (stall cycles, flush entries, issued instructions).
module decode_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_cyc,
  input  logic        flush_entry,
  input  logic [2:0]  issue_n,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [31:0] issue_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall_cyc)   stall_cnt <= stall_cnt + 32'd1;
      if (flush_entry) flush_cnt <= flush_cnt + 16'd1;
      issue_cnt <= issue_cnt + 32'(issue_n);
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue sequencer: picks 0-4 entries per cycle and runs the post-redirect flush.
// Optional performance counters are enabled with `define DECODE_PERF_CNT_EN.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 16,
  parameter int ROB_CNT_W    = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                             Clk,
  input  logic                             Rest,
  input  logic [$clog2(QUEUE_DEPTH+1)-1:0] QueueCount,
  input  logic                             DispatchReady,
  input  logic [ROB_CNT_W-1:0]             RobFreeSlots,
  input  logic                             FlushReq,
  output logic [3:0]                       InInstPort,
  output logic [2:0]                       QueuePop,
  output logic                             QueueFlush,
  output logic                             DecodeStopS,
  output logic                             DecodeFlashS,
  output logic                             FlushBusy
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]                      PerfStallCyc,
  output logic [15:0]                      PerfFlushCnt,
  output logic [31:0]                      PerfIssueCnt
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e          state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            qflush_r;
  logic [2:0]      avail_n;
  logic [2:0]      issue_n;

  always_comb begin
    int unsigned m;
    m = 32'(DECODE_WAYS);
    if (32'(QueueCount) < m)   m = 32'(QueueCount);
    if (32'(RobFreeSlots) < m) m = 32'(RobFreeSlots);
    avail_n = 3'(m);
  end

  assign issue_n = (DispatchReady && (state != ST_FLUSH)) ? avail_n : 3'd0;

  // Reset masks the combinational lane controls so nothing issues while held.
  assign QueuePop     = Rest ? 3'd0 : issue_n;
  assign InInstPort   = thermo(QueuePop);
  assign DecodeStopS  = ~Rest & ~DispatchReady & (state != ST_FLUSH);
  assign QueueFlush   = qflush_r;
  assign DecodeFlashS = (state == ST_FLUSH);
  assign FlushBusy    = (state == ST_FLUSH);

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (FlushReq) begin
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
    end else if (state == ST_FLUSH) begin
      if (flush_cnt != '0) flush_cnt_nxt = flush_cnt - 1'b1;
      else                 state_nxt     = ST_IDLE;
    end else if (QueueCount == '0) begin
      state_nxt = ST_IDLE;
    end else if (issue_n == 3'd0) begin
      state_nxt = ST_STALL;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // QueueFlush follows every sampled redirect by one cycle.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      qflush_r  <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      qflush_r  <= FlushReq;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  decode_perf_cnt u_perf (
    .clk         (Clk),
    .rst         (Rest),
    .stall_cyc   (state == ST_STALL),
    .flush_entry (FlushReq && (state != ST_FLUSH)),
    .issue_n     (QueuePop),
    .stall_cnt   (PerfStallCyc),
    .flush_cnt   (PerfFlushCnt),
    .issue_cnt   (PerfIssueCnt)
  );
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: vector table plus randomized issue cycles, scoreboard-checked.
module tb_decode_issue_ctrl;
  import decode_issue_ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       Rest = 1'b1;
  logic [4:0] QueueCount = '0;
  logic       DispatchReady = 1'b0;
  logic [5:0] RobFreeSlots = '0;
  logic       FlushReq = 1'b0;
  logic [3:0] InInstPort;
  logic [2:0] QueuePop;
  logic       QueueFlush, DecodeStopS, DecodeFlashS, FlushBusy;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] PerfStallCyc, PerfIssueCnt;
  logic [15:0] PerfFlushCnt;
`endif

  decode_issue_ctrl #(.QUEUE_DEPTH(16), .ROB_CNT_W(6), .FLUSH_CYCLES(2)) dut (
    .Clk(Clk), .Rest(Rest), .QueueCount(QueueCount), .DispatchReady(DispatchReady),
    .RobFreeSlots(RobFreeSlots), .FlushReq(FlushReq), .InInstPort(InInstPort),
    .QueuePop(QueuePop), .QueueFlush(QueueFlush), .DecodeStopS(DecodeStopS),
    .DecodeFlashS(DecodeFlashS), .FlushBusy(FlushBusy)
`ifdef DECODE_PERF_CNT_EN
    , .PerfStallCyc(PerfStallCyc), .PerfFlushCnt(PerfFlushCnt), .PerfIssueCnt(PerfIssueCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       chk_st;
    state_e     st;
    logic [3:0] inst;
    logic [2:0] pop;
    logic       stop, qf, df, busy;
  } exp_t;

  typedef struct {
    logic       rest;
    logic [4:0] qc;
    logic       dr;
    logic [5:0] rob;
    logic       fr;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cur = 0;

  function automatic vec_t mkv(input logic rest, input int qc, input logic dr, input int rob,
                               input logic fr, input logic chk_st, input state_e st,
                               input logic [3:0] inst, input int pop, input logic stop,
                               input logic qf, input logic df, input logic busy);
    vec_t v;
    v.rest = rest; v.qc = 5'(qc); v.dr = dr; v.rob = 6'(rob); v.fr = fr;
    v.e.chk_st = chk_st; v.e.st = st; v.e.inst = inst; v.e.pop = 3'(pop);
    v.e.stop = stop; v.e.qf = qf; v.e.df = df; v.e.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, cur, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.chk_st) chk("state", 32'(dut.state), 32'(e.st));
    chk("InInstPort", 32'(InInstPort), 32'(e.inst));
    chk("QueuePop", 32'(QueuePop), 32'(e.pop));
    chk("DecodeStopS", 32'(DecodeStopS), 32'(e.stop));
    chk("QueueFlush", 32'(QueueFlush), 32'(e.qf));
    chk("DecodeFlashS", 32'(DecodeFlashS), 32'(e.df));
    chk("FlushBusy", 32'(FlushBusy), 32'(e.busy));
  endtask

  task automatic apply(input vec_t v);
    @(negedge Clk);
    Rest = v.rest; QueueCount = v.qc; DispatchReady = v.dr;
    RobFreeSlots = v.rob; FlushReq = v.fr;
    sb.push_back(v.e);
    #2;
    compare_out();
    cur++;
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // rest qc dr rob fr | chk st inst pop stop qf df busy
    vecs.push_back(mkv(1, 6, 0, 63, 0, 1, ST_IDLE,  4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 6, 1, 63, 0, 1, ST_IDLE,  4'b1111, 4, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 3, 1,  2, 0, 1, ST_RUN,   4'b0011, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 3, 1,  0, 0, 1, ST_RUN,   4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 5, 0, 63, 0, 1, ST_STALL, 4'b0000, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 5, 1, 63, 0, 1, ST_STALL, 4'b1111, 4, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 63, 0, 1, ST_RUN,   4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 2, 1, 63, 0, 1, ST_IDLE,  4'b0011, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 1,  1, 0, 1, ST_RUN,   4'b0001, 1, 0, 0, 0, 0));
    // single flush pulse, backpressure during flush must not raise stop
    vecs.push_back(mkv(0, 4, 1, 63, 1, 1, ST_RUN,   4'b1111, 4, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 4, 0, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 4, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 4, 1, 63, 0, 1, ST_IDLE,  4'b1111, 4, 0, 0, 0, 0));
    // second redirect at t+2 extends the flush
    vecs.push_back(mkv(0, 4, 1, 63, 1, 1, ST_RUN,   4'b1111, 4, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 4, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 4, 1, 63, 1, 1, ST_FLUSH, 4'b0000, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 4, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 4, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 0, 1, 63, 0, 1, ST_IDLE,  4'b0000, 0, 0, 0, 0, 0));
    // reset during flush aborts it
    vecs.push_back(mkv(0, 2, 1, 63, 1, 1, ST_IDLE,  4'b0011, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 2, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 0, 1, 63, 0, 1, ST_IDLE,  4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 63, 0, 1, ST_IDLE,  4'b0000, 0, 1, 0, 0, 0));
    // full queue, ROB limits; then queue-only limit
    vecs.push_back(mkv(0, 16, 1,  3, 0, 1, ST_IDLE, 4'b0111, 3, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 16, 1, 63, 0, 1, ST_RUN,  4'b1111, 4, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 2, 1, 32, 0, 1, ST_RUN,   4'b0011, 2, 0, 0, 0, 0));

    Rest = 1'b1;
    repeat (2) @(posedge Clk);
    foreach (vecs[i]) apply(vecs[i]);

    // randomized issue cycles outside flush
    for (int k = 0; k < 40; k++) begin
      vec_t v;
      int qc, rob, n;
      logic dr;
      qc  = int'($urandom_range(0, 16));
      rob = int'($urandom_range(0, 63));
      dr  = 1'($urandom_range(0, 1));
      n   = dr ? min3(4, qc, rob) : 0;
      v = mkv(0, qc, dr, rob, 0, 0, ST_IDLE, 4'((1 << n) - 1), n, ~dr, 0, 0, 0);
      apply(v);
    end

    // fresh flush from reset, also exercises the optional flush counter
    apply(mkv(1, 3, 1, 63, 0, 0, ST_IDLE, 4'b0000, 0, 0, 0, 0, 0));
    apply(mkv(0, 0, 1, 63, 0, 1, ST_IDLE, 4'b0000, 0, 0, 0, 0, 0));
`ifdef DECODE_PERF_CNT_EN
    chk("PerfFlushCnt_reset", 32'(PerfFlushCnt), 32'd0);
`endif
    apply(mkv(0, 0, 1, 63, 1, 1, ST_IDLE,  4'b0000, 0, 0, 0, 0, 0));
    apply(mkv(0, 0, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 1, 1, 1));
    apply(mkv(0, 0, 1, 63, 0, 1, ST_FLUSH, 4'b0000, 0, 0, 0, 1, 1));
    apply(mkv(0, 3, 1, 63, 0, 1, ST_IDLE,  4'b0111, 3, 0, 0, 0, 0));
`ifdef DECODE_PERF_CNT_EN
    chk("PerfFlushCnt_one", 32'(PerfFlushCnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
